fp_special_resolve_pipe: RTL and testbench
==========================================

# fp_special_resolve_pipe

Parametrised, pipelined special-value resolver for the FPAU. It takes operands A/B, an operation code and the raw result of the arithmetic core, and substitutes the IEEE-754 special result wherever the operands require one: NaN, ±Inf, ±0 and invalid or divide-by-zero cases. It replaces the per-operation combinational override blocks with one valid/ready pipeline stage pair that serves add, sub, mul, div and sqrt. It also reports per-result exception flags and sticky status.

## Interface
- EXP_W, 8, exponent width; total word W = 1+EXP_W+MAN_W
- MAN_W, 23, mantissa width; QNAN = {1'b0, all-ones exponent, all-ones mantissa} (0x7FFFFFFF at defaults)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  stage 1 can accept (combinational)
- op  in  3  000 add, 001 sub, 010 mul, 011 div, 100 sqrt, others reserved
- a, b  in  W  operands (b ignored for sqrt)
- core_res  in  W  core result for the same operands, sampled with a/b
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- res  out  W  final result
- flag_nv, flag_dz, flag_sp  out  1 each  invalid, divide-by-zero, override-taken (per result)
- sticky_clr  in  1  clear sticky status
- sticky_nv, sticky_dz  out  1 each  accumulated flags

## Operation
- Classification per operand:
  - NaN: exponent all-ones, mantissa ≠ 0. sNaN when mantissa MSB = 0.
  - Inf: exponent all-ones, mantissa = 0.
  - Zero: exponent = 0. Denormals are flushed to zero with their sign kept.
- Any NaN operand gives QNAN. flag_nv = 1 only if some used operand is an sNaN.
- Add/sub: b' = b with its sign XOR (op==sub).
  - Inf and Inf with the same sign gives that Inf. Opposite signs give QNAN, nv.
  - A single Inf operand gives that Inf (b' when the Inf is b).
  - 0 + 0 gives {a.s & b'.s, zero}.
  - a zero gives b'; b zero gives a.
  - Otherwise core_res.
- Mul, with s = a.s^b.s:
  - Inf×0 gives QNAN, nv.
  - Inf×x gives {s,Inf}.
  - 0×x gives {s,0}.
  - Otherwise core_res.
- Div, with s = a.s^b.s:
  - Inf/Inf and 0/0 give QNAN, nv.
  - finite nonzero/0 gives {s,Inf}, dz.
  - Inf/x gives {s,Inf}.
  - 0/x and x/Inf give {s,0}.
  - Otherwise core_res.
- Sqrt:
  - ±0 gives ±0.
  - +Inf gives +Inf.
  - Any negative nonzero input, including -Inf, gives QNAN, nv.
  - Otherwise core_res.
- Reserved op: QNAN, nv=1.
- flag_sp = 1 whenever res ≠ core_res by selection (any override path).
- Stage 1 registers the operand classes, signs, op, core_res and the candidate special word. Stage 2 registers the selected res and flags.
- Sticky update happens on an output handshake (out_valid & out_ready):
  - sticky_x <= (sticky_clr ? 0 : sticky_x) | (hs & flag_x).
  - Clear and a new event in the same cycle leave only the new event.

## Timing
- Latency: 2 cycles from input handshake to out_valid, with no stall.
- Throughput: 1 per cycle.
- Stage enables:
  - en2 = !v2 | out_ready.
  - en1 = !v1 | en2.
  - in_ready = en1.
  - No combinational path from in_valid to out_valid.
- Stall: while out_valid=1 and out_ready=0, res, flags and out_valid hold stable. Stage 1 holds when full, and in_ready drops once both stages are full.
- A bubble is accepted and collapsed: a new input enters stage 1 while stage 2 drains.
- Reset (async assert, sync release):
  - v1 = v2 = 0, out_valid = 0, res = 0, all flags = 0, sticky = 0.
  - in_ready = 1 in the first cycle after release.
  - Reset mid-operation discards in-flight results. No output appears for them.
- Inputs are sampled only when in_valid & in_ready. core_res must be valid in that same cycle.

## Test plan
- Back-to-back stream at defaults:
  - mul a=0x7F800000, b=0x00000000 -> res 0x7FFFFFFF, nv=1, sp=1 on cycle 2.
  - Next item, mul 0x3F800000×0x40000000 with core_res 0x40000000 -> res 0x40000000, sp=0 on cycle 3.
- Add/sub signs:
  - sub 0x7F800000 − 0x7F800000 -> 0x7FFFFFFF, nv.
  - add 0x80000000 + 0x80000000 -> 0x80000000.
  - sub 0x00000000 − 0x00000000 -> 0x00000000.
- Div and sqrt:
  - div 0xBF800000/0x00000000 -> 0xFF800000, dz=1.
  - sqrt 0x80000000 -> 0x80000000.
  - sqrt 0xC0800000 -> 0x7FFFFFFF, nv.
- sNaN vs qNaN:
  - add 0x7F800001 + 1.0 -> QNAN, nv=1.
  - add 0x7FC00000 + 1.0 -> QNAN, nv=0.
- Backpressure: hold out_ready=0 for 5 cycles with 3 inputs offered.
  - in_ready drops after 2 accepts.
  - res stays stable.
  - All 3 results emerge in order once out_ready=1.
- Sticky and reset:
  - nv result handshaked in the same cycle as sticky_clr -> sticky_nv=1.
  - sticky_clr alone -> 0.
  - rst_n pulsed low with both stages full -> out_valid=0 immediately, and no stale output after release.
- Parametrised build: EXP_W=5, MAN_W=10, div 1.0/0 (0x3C00/0x0000) -> 0x7C00, dz=1.

Source files
------------

// File: rtl/fp_special_resolve_pipe.sv
// Two-stage valid/ready special-value resolver for the FPAU: classifies A/B, picks the IEEE-754
// special result (NaN, Inf, zero) when the operands demand one, otherwise passes core_res through.
module fp_special_resolve_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] core_res,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic         flag_nv,
  output logic         flag_dz,
  output logic         flag_sp,
  input  logic         sticky_clr,
  output logic         sticky_nv,
  output logic         sticky_dz
);

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpSub  = 3'b001;
  localparam logic [2:0] OpMul  = 3'b010;
  localparam logic [2:0] OpDiv  = 3'b011;
  localparam logic [2:0] OpSqrt = 3'b100;

  localparam logic [W-1:0] QNAN    = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
  localparam logic [W-1:0] POS_INF = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

  // Operand classification
  logic             a_s, b_s, bs_eff, s_prod;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic             a_nan, a_snan, a_inf, a_zero;
  logic             b_nan, b_snan, b_inf, b_zero;

  always_comb begin
    a_s    = a[W-1];
    b_s    = b[W-1];
    a_exp  = a[W-2 -: EXP_W];
    b_exp  = b[W-2 -: EXP_W];
    a_man  = a[MAN_W-1:0];
    b_man  = b[MAN_W-1:0];
    a_nan  = (&a_exp) & (|a_man);
    b_nan  = (&b_exp) & (|b_man);
    a_snan = a_nan & ~a_man[MAN_W-1];
    b_snan = b_nan & ~b_man[MAN_W-1];
    a_inf  = (&a_exp) & ~(|a_man);
    b_inf  = (&b_exp) & ~(|b_man);
    // Denormals count as zero; their sign is kept
    a_zero = ~(|a_exp);
    b_zero = ~(|b_exp);
    bs_eff = b_s ^ (op == OpSub);
    s_prod = a_s ^ b_s;
  end

  // Special-result selection
  logic [W-1:0] spec_d;
  logic         nv_d, dz_d, sp_d;

  always_comb begin
    spec_d = QNAN;
    nv_d   = 1'b0;
    dz_d   = 1'b0;
    sp_d   = 1'b1;
    case (op)
      OpAdd, OpSub: begin
        if (a_nan || b_nan) begin
          nv_d = a_snan | b_snan;
        end else if (a_inf && b_inf) begin
          if (a_s == bs_eff) spec_d = a;
          else               nv_d   = 1'b1;
        end else if (a_inf) begin
          spec_d = a;
        end else if (b_inf) begin
          spec_d = {bs_eff, b[W-2:0]};
        end else if (a_zero && b_zero) begin
          spec_d = {a_s & bs_eff, {(W-1){1'b0}}};
        end else if (a_zero) begin
          spec_d = {bs_eff, b[W-2:0]};
        end else if (b_zero) begin
          spec_d = a;
        end else begin
          sp_d = 1'b0;
        end
      end
      OpMul: begin
        if (a_nan || b_nan) begin
          nv_d = a_snan | b_snan;
        end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
          nv_d = 1'b1;
        end else if (a_inf || b_inf) begin
          spec_d = {s_prod, POS_INF[W-2:0]};
        end else if (a_zero || b_zero) begin
          spec_d = {s_prod, {(W-1){1'b0}}};
        end else begin
          sp_d = 1'b0;
        end
      end
      OpDiv: begin
        if (a_nan || b_nan) begin
          nv_d = a_snan | b_snan;
        end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
          nv_d = 1'b1;
        end else if (a_inf) begin
          spec_d = {s_prod, POS_INF[W-2:0]};
        end else if (b_zero) begin
          spec_d = {s_prod, POS_INF[W-2:0]};
          dz_d   = 1'b1;
        end else if (a_zero || b_inf) begin
          spec_d = {s_prod, {(W-1){1'b0}}};
        end else begin
          sp_d = 1'b0;
        end
      end
      OpSqrt: begin
        if (a_nan) begin
          nv_d = a_snan;
        end else if (a_zero) begin
          spec_d = {a_s, {(W-1){1'b0}}};
        end else if (a_s) begin
          nv_d = 1'b1;
        end else if (a_inf) begin
          spec_d = POS_INF;
        end else begin
          sp_d = 1'b0;
        end
      end
      default: nv_d = 1'b1;
    endcase
  end

  // Pipeline control
  logic v1, v2, en1, en2, hs;

  assign en2       = ~v2 | out_ready;
  assign en1       = ~v1 | en2;
  assign in_ready  = en1;
  assign out_valid = v2;
  assign hs        = v2 & out_ready;

  logic [W-1:0] s1_spec, s1_core;
  logic         s1_nv, s1_dz, s1_sp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      s1_spec <= '0;
      s1_core <= '0;
      s1_nv   <= 1'b0;
      s1_dz   <= 1'b0;
      s1_sp   <= 1'b0;
    end else if (en1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_spec <= spec_d;
        s1_core <= core_res;
        s1_nv   <= nv_d;
        s1_dz   <= dz_d;
        s1_sp   <= sp_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2      <= 1'b0;
      res     <= '0;
      flag_nv <= 1'b0;
      flag_dz <= 1'b0;
      flag_sp <= 1'b0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        res     <= s1_sp ? s1_spec : s1_core;
        flag_nv <= s1_nv;
        flag_dz <= s1_dz;
        flag_sp <= s1_sp;
      end
    end
  end

  // A clear coinciding with a new event keeps the new event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_nv <= 1'b0;
      sticky_dz <= 1'b0;
    end else begin
      sticky_nv <= (sticky_clr ? 1'b0 : sticky_nv) | (hs & flag_nv);
      sticky_dz <= (sticky_clr ? 1'b0 : sticky_dz) | (hs & flag_dz);
    end
  end

endmodule

// File: tb/tb_fp_special_resolve_pipe.sv
// Directed bench for fp_special_resolve_pipe: default 32-bit build plus a 16-bit build.
module tb_fp_special_resolve_pipe;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MUL = 3'b010, DIV = 3'b011, SQRT = 3'b100;
  localparam logic [31:0] QN = 32'h7FFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0, b = '0, core_res = '0, res;
  logic        flag_nv, flag_dz, flag_sp, sticky_clr = 1'b0, sticky_nv, sticky_dz;

  logic        s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b1;
  logic [2:0]  s_op = 3'b000;
  logic [15:0] s_a = '0, s_b = '0, s_core = '0, s_res;
  logic        s_nv, s_dz, s_sp, s_clr = 1'b0, s_snv, s_sdz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_special_resolve_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .core_res(core_res), .out_valid(out_valid), .out_ready(out_ready), .res(res),
    .flag_nv(flag_nv), .flag_dz(flag_dz), .flag_sp(flag_sp), .sticky_clr(sticky_clr),
    .sticky_nv(sticky_nv), .sticky_dz(sticky_dz)
  );

  fp_special_resolve_pipe #(.EXP_W(5), .MAN_W(10)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op), .a(s_a),
    .b(s_b), .core_res(s_core), .out_valid(s_out_valid), .out_ready(s_out_ready), .res(s_res),
    .flag_nv(s_nv), .flag_dz(s_dz), .flag_sp(s_sp), .sticky_clr(s_clr),
    .sticky_nv(s_snv), .sticky_dz(s_sdz)
  );

  // Drives one item into an idle pipe and returns its result; got=0 if nothing appeared.
  task automatic drive_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] vc, output logic got, output logic [34:0] obs);
    in_valid = 1'b1; op = o; a = va; b = vb; core_res = vc; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 1'b0;
    obs = '0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) begin
        got = 1'b1;
        obs = {res, flag_nv, flag_dz, flag_sp};
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, out_valid, res, flag_nv, flag_dz, flag_sp, sticky_nv, sticky_dz} !==
        {1'b1, 1'b0, 32'h0, 5'b0}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b ov=%b res=%h nv=%b dz=%b sp=%b snv=%b sdz=%b",
               in_ready, out_valid, res, flag_nv, flag_dz, flag_sp, sticky_nv, sticky_dz);
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; op = MUL; a = 32'h7F80_0000; b = 32'h0; core_res = 32'h1234_5678;
    out_ready = 1'b1;
    @(posedge clk); #1;
    op = MUL; a = 32'h3F80_0000; b = 32'h4000_0000; core_res = 32'h4000_0000;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_latency: out_valid=%b after 1 cycle, want 0", out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, res, flag_nv, flag_sp} !== {1'b1, QN, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL b2b_item0: ov=%b res=%h nv=%b sp=%b want 1 %h 1 1",
               out_valid, res, flag_nv, flag_sp, QN);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, res, flag_nv, flag_sp} !== {1'b1, 32'h4000_0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_item1: ov=%b res=%h nv=%b sp=%b want 1 40000000 0 0",
               out_valid, res, flag_nv, flag_sp);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_vectors();
    logic [2:0]  ops [10] = '{SUB, ADD, SUB, DIV, SQRT, SQRT, ADD, ADD, 3'b101, DIV};
    logic [31:0] va  [10] = '{32'h7F800000, 32'h80000000, 32'h00000000, 32'hBF800000,
                              32'h80000000, 32'hC0800000, 32'h7F800001, 32'h7FC00000,
                              32'h3F800000, 32'h00000000};
    logic [31:0] vb  [10] = '{32'h7F800000, 32'h80000000, 32'h00000000, 32'h00000000,
                              32'h0, 32'h0, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                              32'hFF800000};
    // expected {res, nv, dz, sp}
    logic [34:0] exp_v [10] = '{{QN, 3'b101}, {32'h80000000, 3'b001}, {32'h00000000, 3'b001},
                                {32'hFF800000, 3'b011}, {32'h80000000, 3'b001}, {QN, 3'b101},
                                {QN, 3'b101}, {QN, 3'b001}, {QN, 3'b101},
                                {32'h80000000, 3'b001}};
    logic        got;
    logic [34:0] obs;
    for (int i = 0; i < 10; i++) begin
      drive_op(ops[i], va[i], vb[i], 32'h1234_5678, got, obs);
      checks++;
      if (!got || obs !== exp_v[i]) begin
        errors++;
        $display("FAIL vec%0d: got=%b res=%h nvdzsp=%b want res=%h nvdzsp=%b", i, got,
                 obs[34:3], obs[2:0], exp_v[i][34:3], exp_v[i][2:0]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; op = MUL; a = 32'h3F80_0000; b = 32'h4000_0000; core_res = 32'h4000_0000;
    @(posedge clk); #1;
    op = ADD; a = 32'h7F80_0000; b = 32'h3F80_0000; core_res = 32'h1111_1111;
    @(posedge clk); #1;
    op = SUB; a = 32'h3F80_0000; b = 32'h7F80_0000; core_res = 32'h2222_2222;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({in_ready, out_valid, res, flag_sp} !== {1'b0, 1'b1, 32'h4000_0000, 1'b0}) begin
        errors++;
        $display("FAIL bp_stall%0d: rdy=%b ov=%b res=%h sp=%b want 0 1 40000000 0",
                 i, in_ready, out_valid, res, flag_sp);
      end
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, res, flag_sp} !== {1'b1, 32'h7F80_0000, 1'b1}) begin
      errors++;
      $display("FAIL bp_item1: ov=%b res=%h sp=%b want 1 7f800000 1", out_valid, res, flag_sp);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, res, flag_sp} !== {1'b1, 32'hFF80_0000, 1'b1}) begin
      errors++;
      $display("FAIL bp_item2: ov=%b res=%h sp=%b want 1 ff800000 1", out_valid, res, flag_sp);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_sticky();
    logic        got;
    logic [34:0] obs;
    checks++;
    if ({sticky_nv, sticky_dz} !== 2'b11) begin
      errors++; $display("FAIL sticky_accum: nv=%b dz=%b want 1 1", sticky_nv, sticky_dz);
    end
    drive_op(MUL, 32'h7F80_0000, 32'h0, 32'h0, got, obs);
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({got, sticky_nv, sticky_dz} !== 3'b110) begin
      errors++;
      $display("FAIL sticky_clr_event: got=%b nv=%b dz=%b want 1 1 0", got, sticky_nv, sticky_dz);
    end
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    checks++;
    if ({sticky_nv, sticky_dz} !== 2'b00) begin
      errors++; $display("FAIL sticky_clr_only: nv=%b dz=%b want 0 0", sticky_nv, sticky_dz);
    end
  endtask

  task automatic test_small_param();
    s_in_valid = 1'b1; s_op = DIV; s_a = 16'h3C00; s_b = 16'h0000; s_core = 16'h0000;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({s_out_valid, s_res, s_nv, s_dz} !== {1'b1, 16'h7C00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL small_div0: ov=%b res=%h nv=%b dz=%b want 1 7c00 0 1",
               s_out_valid, s_res, s_nv, s_dz);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    in_valid = 1'b1; op = MUL; a = 32'h7F80_0000; b = 32'h0; core_res = 32'h0;
    @(posedge clk); #1;
    op = DIV; a = 32'h3F80_0000; b = 32'h0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      errors++; $display("FAIL rst_full: ov=%b rdy=%b want 1 0", out_valid, in_ready);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, res, flag_nv, flag_dz, flag_sp} !== {2'b01, 32'h0, 3'b000}) begin
      errors++;
      $display("FAIL rst_async: ov=%b rdy=%b res=%h nv=%b dz=%b sp=%b want 0 1 0 0 0 0",
               out_valid, in_ready, res, flag_nv, flag_dz, flag_sp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL rst_stale%0d: out_valid=%b want 0", i, out_valid);
      end
    end
  endtask

  initial begin
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_back_to_back();
    test_vectors();
    test_backpressure();
    test_sticky();
    test_small_param();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
